csr_machine_file: RTL and testbench

Parametrised machine-mode CSR file for the single-hart RV32 core, succeeding the fixed-function CSR block. It adds the following:
- configurable counter width and a configurable number of event-driven hpm counters
- mcountinhibit
- vectored mtvec mode
- mtval capture
- registered interrupt-pending sampling
- an interrupt arbiter with priority encoding that tells the core when and where to trap

It sits beside the decode/execute stage and is read combinationally by CSR instructions.

---
 rtl/csr_machine_file.sv | 265 ++++++++++++++++++++++++++
 tb/tb_csr_machine_file.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_machine_file.sv
// Machine-mode CSR file for a single-hart RV32 core.
// Holds mstatus/mie/mip/mtvec/mepc/mcause/mtval/mscratch, mcountinhibit,
// mcycle/minstret and HPM_COUNTERS event counters, and arbitrates interrupts.
// Ports:
//   clock, reset_n                 - core clock, async active-low reset
//   address/read_value/read_legal  - combinational CSR read port
//   write_value/write_enable       - CSR write commit
//   trap*, return_from_trap        - trap entry / mret commit from the core
//   retire, hpm_event              - counter increment sources
//   external/timer/software_interrupt - raw interrupt sources (sampled into mip)
//   interrupt_request/interrupt_code  - highest-priority enabled pending interrupt
//   trap_target, mepc_value        - next PC on trap / return address for mret
module csr_machine_file #(
    parameter int unsigned HPM_COUNTERS    = 4,
    parameter int unsigned COUNTER_WIDTH   = 64,
    parameter int unsigned VECTORED_ENABLE = 1,
    parameter logic [31:0] HART_ID         = 32'h0
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [11:0]             address,
    output logic [31:0]             read_value,
    output logic                    read_legal,
    input  logic [31:0]             write_value,
    input  logic                    write_enable,
    input  logic                    trap,
    input  logic                    trap_interrupt,
    input  logic [4:0]              trap_code,
    input  logic [31:0]             trap_pc,
    input  logic [31:0]             trap_value,
    input  logic                    return_from_trap,
    input  logic                    retire,
    input  logic [HPM_COUNTERS-1:0] hpm_event,
    input  logic                    external_interrupt,
    input  logic                    timer_interrupt,
    input  logic                    software_interrupt,
    output logic                    interrupt_request,
    output logic [4:0]              interrupt_code,
    output logic [31:0]             trap_target,
    output logic [31:0]             mepc_value
);

    localparam int unsigned CW    = COUNTER_WIDTH;
    localparam int unsigned HPM_N = HPM_COUNTERS;
    localparam logic [31:0] MIE_MASK     = 32'h0000_0888;
    localparam logic [31:0] MISA_VALUE   = 32'h4000_0100;
    localparam logic [31:0] INHIBIT_MASK =
        32'(64'h5 | (((64'h1 << HPM_N) - 64'h1) << 3));

    // Architectural state
    logic          mstatus_mie_q, mstatus_mie_d;
    logic          mstatus_mpie_q, mstatus_mpie_d;
    logic [31:0]   mie_q, mie_d;
    logic [31:0]   mip_q, mip_d;
    logic [29:0]   mtvec_base_q, mtvec_base_d;
    logic          mtvec_mode_q, mtvec_mode_d;
    logic [29:0]   mepc_q, mepc_d;
    logic          mcause_int_q, mcause_int_d;
    logic [4:0]    mcause_code_q, mcause_code_d;
    logic [31:0]   mtval_q, mtval_d;
    logic [31:0]   mscratch_q, mscratch_d;
    logic [31:0]   minhibit_q, minhibit_d;
    logic [CW-1:0] mcycle_q, mcycle_d;
    logic [CW-1:0] minstret_q, minstret_d;
    logic [CW-1:0] hpm_cnt_q [HPM_N];
    logic [CW-1:0] hpm_cnt_d [HPM_N];
    logic [31:0]   hpm_evt_q [HPM_N];
    logic [31:0]   hpm_evt_d [HPM_N];

    logic [31:0]   pending_c;
    logic          unused_trap_pc_lsb;

    assign unused_trap_pc_lsb = &{1'b0, trap_pc[1:0]};

    // Replace one 32-bit half of a counter; bits above the counter width drop out.
    function automatic logic [CW-1:0] cnt_write(input logic [CW-1:0] cur,
                                                input logic hi,
                                                input logic [31:0] val);
        logic [63:0] t;
        t = 64'(cur);
        if (hi) t[63:32] = val;
        else    t[31:0]  = val;
        return CW'(t);
    endfunction

    function automatic logic [31:0] cnt_hi(input logic [CW-1:0] cur);
        return 32'(64'(cur) >> 32);
    endfunction

    // Next-state: counters first, then trap > mret > write; a counter write wins over its increment
    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_d          = mie_q;
        mtvec_base_d   = mtvec_base_q;
        mtvec_mode_d   = mtvec_mode_q;
        mepc_d         = mepc_q;
        mcause_int_d   = mcause_int_q;
        mcause_code_d  = mcause_code_q;
        mtval_d        = mtval_q;
        mscratch_d     = mscratch_q;
        minhibit_d     = minhibit_q;
        mip_d          = {20'b0, external_interrupt, 3'b0, timer_interrupt, 3'b0,
                          software_interrupt, 3'b0};

        mcycle_d   = minhibit_q[0] ? mcycle_q : mcycle_q + CW'(1);
        minstret_d = minhibit_q[2] ? minstret_q : minstret_q + CW'(retire);
        for (int i = 0; i < int'(HPM_N); i++) begin
            hpm_cnt_d[i] = minhibit_q[i+3] ? hpm_cnt_q[i]
                                           : hpm_cnt_q[i] + CW'(hpm_event[i]);
            hpm_evt_d[i] = hpm_evt_q[i];
        end

        if (trap) begin
            mcause_int_d   = trap_interrupt;
            mcause_code_d  = trap_code;
            mepc_d         = trap_pc[31:2];
            mtval_d        = trap_value;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end else if (return_from_trap) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end else if (write_enable) begin
            case (address)
                12'h300: begin
                    mstatus_mie_d  = write_value[3];
                    mstatus_mpie_d = write_value[7];
                end
                12'h304: mie_d = write_value & MIE_MASK;
                12'h305: begin
                    mtvec_base_d = write_value[31:2];
                    // Only MODE=1 with vectoring enabled is kept; everything else is direct
                    mtvec_mode_d = (VECTORED_ENABLE != 0) && (write_value[1:0] == 2'b01);
                end
                12'h320: minhibit_d = write_value & INHIBIT_MASK;
                12'h340: mscratch_d = write_value;
                12'h341: mepc_d     = write_value[31:2];
                12'h342: begin
                    mcause_int_d  = write_value[31];
                    mcause_code_d = write_value[4:0];
                end
                12'h343: mtval_d    = write_value;
                12'hB00: mcycle_d   = cnt_write(mcycle_q, 1'b0, write_value);
                12'hB80: mcycle_d   = cnt_write(mcycle_q, 1'b1, write_value);
                12'hB02: minstret_d = cnt_write(minstret_q, 1'b0, write_value);
                12'hB82: minstret_d = cnt_write(minstret_q, 1'b1, write_value);
                default: begin
                    for (int i = 0; i < int'(HPM_N); i++) begin
                        if (address == 12'hB03 + 12'(i))
                            hpm_cnt_d[i] = cnt_write(hpm_cnt_q[i], 1'b0, write_value);
                        if (address == 12'hB83 + 12'(i))
                            hpm_cnt_d[i] = cnt_write(hpm_cnt_q[i], 1'b1, write_value);
                        if (address == 12'h323 + 12'(i))
                            hpm_evt_d[i] = write_value;
                    end
                end
            endcase
        end
    end

    // State registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= '0;
            mip_q          <= '0;
            mtvec_base_q   <= '0;
            mtvec_mode_q   <= 1'b0;
            mepc_q         <= '0;
            mcause_int_q   <= 1'b0;
            mcause_code_q  <= '0;
            mtval_q        <= '0;
            mscratch_q     <= '0;
            minhibit_q     <= '0;
            mcycle_q       <= '0;
            minstret_q     <= '0;
            for (int i = 0; i < int'(HPM_N); i++) begin
                hpm_cnt_q[i] <= '0;
                hpm_evt_q[i] <= '0;
            end
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_q          <= mie_d;
            mip_q          <= mip_d;
            mtvec_base_q   <= mtvec_base_d;
            mtvec_mode_q   <= mtvec_mode_d;
            mepc_q         <= mepc_d;
            mcause_int_q   <= mcause_int_d;
            mcause_code_q  <= mcause_code_d;
            mtval_q        <= mtval_d;
            mscratch_q     <= mscratch_d;
            minhibit_q     <= minhibit_d;
            mcycle_q       <= mcycle_d;
            minstret_q     <= minstret_d;
            for (int i = 0; i < int'(HPM_N); i++) begin
                hpm_cnt_q[i] <= hpm_cnt_d[i];
                hpm_evt_q[i] <= hpm_evt_d[i];
            end
        end
    end

    // Combinational read port
    always_comb begin
        read_value = 32'h0;
        read_legal = 1'b1;
        case (address)
            12'h300: read_value = {19'b0, 2'b11, 3'b0, mstatus_mpie_q, 3'b0,
                                   mstatus_mie_q, 3'b0};
            12'h301: read_value = MISA_VALUE;
            12'h304: read_value = mie_q;
            12'h305: read_value = {mtvec_base_q, 1'b0, mtvec_mode_q};
            12'h320: read_value = minhibit_q;
            12'h340: read_value = mscratch_q;
            12'h341: read_value = {mepc_q, 2'b00};
            12'h342: read_value = {mcause_int_q, 26'b0, mcause_code_q};
            12'h343: read_value = mtval_q;
            12'h344: read_value = mip_q;
            12'hB00: read_value = mcycle_q[31:0];
            12'hB80: read_value = cnt_hi(mcycle_q);
            12'hB02: read_value = minstret_q[31:0];
            12'hB82: read_value = cnt_hi(minstret_q);
            12'hF11, 12'hF12, 12'hF13: read_value = 32'h0;
            12'hF14: read_value = HART_ID;
            default: begin
                // HPM windows: index 3..31 legal, unimplemented indices read 0
                if (address[4:0] >= 5'd3 &&
                    (address[11:5] == 7'b1011_000 || address[11:5] == 7'b1011_100 ||
                     address[11:5] == 7'b0011_001)) begin
                    for (int i = 0; i < int'(HPM_N); i++) begin
                        if (address[4:0] == 5'(i + 3)) begin
                            if (address[11:5] == 7'b1011_000)
                                read_value = hpm_cnt_q[i][31:0];
                            else if (address[11:5] == 7'b1011_100)
                                read_value = cnt_hi(hpm_cnt_q[i]);
                            else
                                read_value = hpm_evt_q[i];
                        end
                    end
                end else begin
                    read_legal = 1'b0;
                end
            end
        endcase
    end

    // Interrupt arbiter: MEI > MSI > MTI
    assign pending_c         = mip_q & mie_q;
    assign interrupt_request = mstatus_mie_q & (|pending_c);

    always_comb begin
        interrupt_code = 5'd0;
        if (pending_c[11])     interrupt_code = 5'd11;
        else if (pending_c[3]) interrupt_code = 5'd3;
        else if (pending_c[7]) interrupt_code = 5'd7;
    end

    assign trap_target = {mtvec_base_q, 2'b00} +
                         ((mtvec_mode_q && trap_interrupt) ? {25'b0, trap_code, 2'b00}
                                                           : 32'h0);
    assign mepc_value  = {mepc_q, 2'b00};

endmodule

// File: tb/tb_csr_machine_file.sv
module tb_csr_machine_file;

    localparam longint unsigned CMASK = 64'hFF_FFFF_FFFF;
    localparam logic [31:0]     HART  = 32'h5;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [11:0] address;
    logic [31:0] write_value;
    logic        write_enable;
    logic        trap, trap_interrupt, return_from_trap, retire;
    logic [4:0]  trap_code;
    logic [31:0] trap_pc, trap_value;
    logic [3:0]  hpm_event;
    logic        ext_irq, tim_irq, sw_irq;

    logic [31:0] read_value, trap_target, mepc_value;
    logic        read_legal, interrupt_request;
    logic [4:0]  interrupt_code;

    logic [31:0] nv_read_value, nv_trap_target, nv_mepc_value;
    logic        nv_read_legal, nv_interrupt_request;
    logic [4:0]  nv_interrupt_code;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    csr_machine_file #(.HPM_COUNTERS(4), .COUNTER_WIDTH(40), .VECTORED_ENABLE(1),
                       .HART_ID(HART)) u_dut (
        .clock(clock), .reset_n(reset_n), .address(address), .read_value(read_value),
        .read_legal(read_legal), .write_value(write_value), .write_enable(write_enable),
        .trap(trap), .trap_interrupt(trap_interrupt), .trap_code(trap_code),
        .trap_pc(trap_pc), .trap_value(trap_value), .return_from_trap(return_from_trap),
        .retire(retire), .hpm_event(hpm_event), .external_interrupt(ext_irq),
        .timer_interrupt(tim_irq), .software_interrupt(sw_irq),
        .interrupt_request(interrupt_request), .interrupt_code(interrupt_code),
        .trap_target(trap_target), .mepc_value(mepc_value));

    csr_machine_file #(.HPM_COUNTERS(4), .COUNTER_WIDTH(64), .VECTORED_ENABLE(0),
                       .HART_ID(HART)) u_dut_nv (
        .clock(clock), .reset_n(reset_n), .address(address), .read_value(nv_read_value),
        .read_legal(nv_read_legal), .write_value(write_value), .write_enable(write_enable),
        .trap(trap), .trap_interrupt(trap_interrupt), .trap_code(trap_code),
        .trap_pc(trap_pc), .trap_value(trap_value), .return_from_trap(return_from_trap),
        .retire(retire), .hpm_event(hpm_event), .external_interrupt(ext_irq),
        .timer_interrupt(tim_irq), .software_interrupt(sw_irq),
        .interrupt_request(nv_interrupt_request), .interrupt_code(nv_interrupt_code),
        .trap_target(nv_trap_target), .mepc_value(nv_mepc_value));

    // Reference model state (architectural view)
    bit              m_mie_st, m_mpie;
    logic [31:0]     m_mie, m_mip, m_mtvec, m_mtvec_nv, m_mepc, m_mcause, m_mtval;
    logic [31:0]     m_scratch, m_minh;
    longint unsigned m_cyc, m_ret;
    longint unsigned m_hpm [4];
    logic [31:0]     m_evt [4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mie_st = 0; m_mpie = 0;
        m_mie = 0; m_mip = 0; m_mtvec = 0; m_mtvec_nv = 0; m_mepc = 0;
        m_mcause = 0; m_mtval = 0; m_scratch = 0; m_minh = 0;
        m_cyc = 0; m_ret = 0;
        for (int i = 0; i < 4; i++) begin m_hpm[i] = 0; m_evt[i] = 0; end
    endtask

    function automatic longint unsigned cwrite(input longint unsigned cur, input bit hi,
                                               input logic [31:0] v);
        longint unsigned vv;
        vv = 64'(v);
        if (hi) return ((vv << 32) | (cur & 64'hFFFF_FFFF)) & CMASK;
        return (cur & ~64'hFFFF_FFFF) | vv;
    endfunction

    // Expected read: {legal, value}
    function automatic logic [32:0] model_read(input logic [11:0] a);
        int idx;
        case (a)
            12'h300: return {1'b1, 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie_st) << 3)};
            12'h301: return {1'b1, 32'h4000_0100};
            12'h304: return {1'b1, m_mie};
            12'h305: return {1'b1, m_mtvec};
            12'h320: return {1'b1, m_minh};
            12'h340: return {1'b1, m_scratch};
            12'h341: return {1'b1, m_mepc};
            12'h342: return {1'b1, m_mcause};
            12'h343: return {1'b1, m_mtval};
            12'h344: return {1'b1, m_mip};
            12'hB00: return {1'b1, 32'(m_cyc)};
            12'hB80: return {1'b1, 32'(m_cyc >> 32)};
            12'hB02: return {1'b1, 32'(m_ret)};
            12'hB82: return {1'b1, 32'(m_ret >> 32)};
            12'hF11, 12'hF12, 12'hF13: return {1'b1, 32'h0};
            12'hF14: return {1'b1, HART};
            default: ;
        endcase
        if (a >= 12'hB03 && a <= 12'hB1F) begin
            idx = int'(a) - 'hB03;
            return {1'b1, (idx < 4) ? 32'(m_hpm[idx]) : 32'h0};
        end
        if (a >= 12'hB83 && a <= 12'hB9F) begin
            idx = int'(a) - 'hB83;
            return {1'b1, (idx < 4) ? 32'(m_hpm[idx] >> 32) : 32'h0};
        end
        if (a >= 12'h323 && a <= 12'h33F) begin
            idx = int'(a) - 'h323;
            return {1'b1, (idx < 4) ? m_evt[idx] : 32'h0};
        end
        return 33'h0;
    endfunction

    task automatic model_update();
        longint unsigned cyc_n, ret_n;
        longint unsigned hpm_n [4];
        cyc_n = m_minh[0] ? m_cyc : (m_cyc + 1) & CMASK;
        ret_n = m_minh[2] ? m_ret : (m_ret + 64'(retire)) & CMASK;
        for (int i = 0; i < 4; i++)
            hpm_n[i] = m_minh[i+3] ? m_hpm[i] : (m_hpm[i] + 64'(hpm_event[i])) & CMASK;
        if (trap) begin
            m_mcause = trap_interrupt ? (32'h8000_0000 | 32'(trap_code)) : 32'(trap_code);
            m_mepc   = trap_pc & ~32'h3;
            m_mtval  = trap_value;
            m_mpie   = m_mie_st;
            m_mie_st = 0;
        end else if (return_from_trap) begin
            m_mie_st = m_mpie;
            m_mpie   = 1;
        end else if (write_enable) begin
            case (address)
                12'h300: begin m_mie_st = write_value[3]; m_mpie = write_value[7]; end
                12'h304: m_mie = write_value & 32'h888;
                12'h305: begin
                    m_mtvec    = (write_value & ~32'h3) | ((write_value[1:0] == 2'd1) ? 32'h1 : 32'h0);
                    m_mtvec_nv = write_value & ~32'h3;
                end
                12'h320: m_minh    = write_value & 32'h7D;
                12'h340: m_scratch = write_value;
                12'h341: m_mepc    = write_value & ~32'h3;
                12'h342: m_mcause  = write_value & 32'h8000_001F;
                12'h343: m_mtval   = write_value;
                12'hB00: cyc_n = cwrite(m_cyc, 0, write_value);
                12'hB80: cyc_n = cwrite(m_cyc, 1, write_value);
                12'hB02: ret_n = cwrite(m_ret, 0, write_value);
                12'hB82: ret_n = cwrite(m_ret, 1, write_value);
                default: ;
            endcase
            for (int i = 0; i < 4; i++) begin
                if (address == 12'hB03 + 12'(i)) hpm_n[i] = cwrite(m_hpm[i], 0, write_value);
                if (address == 12'hB83 + 12'(i)) hpm_n[i] = cwrite(m_hpm[i], 1, write_value);
                if (address == 12'h323 + 12'(i)) m_evt[i] = write_value;
            end
        end
        m_cyc = cyc_n; m_ret = ret_n;
        for (int i = 0; i < 4; i++) m_hpm[i] = hpm_n[i];
        m_mip = (32'(ext_irq) << 11) | (32'(tim_irq) << 7) | (32'(sw_irq) << 3);
    endtask

    // Compare all outputs against the model at the falling edge, then advance one cycle
    task automatic tick();
        logic [32:0] rd;
        logic [31:0] pend, base, exp_tgt;
        logic [4:0]  exp_code;
        @(negedge clock);
        rd   = model_read(address);
        pend = m_mip & m_mie;
        exp_code = pend[11] ? 5'd11 : pend[3] ? 5'd3 : pend[7] ? 5'd7 : 5'd0;
        base = m_mtvec & ~32'h3;
        exp_tgt = (m_mtvec[0] && trap_interrupt) ? base + 32'(trap_code) * 32'd4 : base;
        check("read_value", read_value, rd[31:0]);
        check("read_legal", 32'(read_legal), 32'(rd[32]));
        check("irq_req", 32'(interrupt_request), 32'(m_mie_st && pend != 0));
        check("irq_code", 32'(interrupt_code), 32'(exp_code));
        check("trap_target", trap_target, exp_tgt);
        check("mepc_value", mepc_value, m_mepc);
        check("nv_irq_req", 32'(nv_interrupt_request), 32'(m_mie_st && pend != 0));
        check("nv_irq_code", 32'(nv_interrupt_code), 32'(exp_code));
        check("nv_trap_target", nv_trap_target, m_mtvec_nv);
        check("nv_mepc_value", nv_mepc_value, m_mepc);
        if (address == 12'h305) begin
            check("nv_mtvec", nv_read_value, m_mtvec_nv);
            check("nv_mtvec_legal", 32'(nv_read_legal), 32'h1);
        end
        @(posedge clock);
        model_update();
        #1;
    endtask

    task automatic idle();
        write_enable = 0; trap = 0; return_from_trap = 0; retire = 0; hpm_event = 0;
        trap_interrupt = 0; trap_code = 0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] v);
        address = a; write_value = v; write_enable = 1;
        tick();
        write_enable = 0;
    endtask

    // Combinational read with no clock edge in between
    task automatic peek(input string tag, input logic [11:0] a, input logic [31:0] exp);
        address = a;
        #1;
        check(tag, read_value, exp);
    endtask

    logic [11:0] addr_pool [32] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h320, 12'h323,
        12'h324, 12'h326, 12'h327, 12'h33F, 12'h340, 12'h341, 12'h342, 12'h343, 12'h344,
        12'hB00, 12'hB02, 12'hB03, 12'hB04, 12'hB06, 12'hB07, 12'hB1F, 12'hB80, 12'hB82,
        12'hB83, 12'hB86, 12'hB9F, 12'hF11, 12'hF14, 12'h7C0, 12'hC00, 12'h305};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 0; address = 12'h300; write_value = 0; trap_pc = 0; trap_value = 0;
        ext_irq = 0; tim_irq = 0; sw_irq = 0;
        idle();
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        // Reset state
        peek("rst_mstatus", 12'h300, 32'h1800);
        peek("rst_mcycle", 12'hB00, 32'h0);
        check("rst_irq", 32'(interrupt_request), 32'h0);
        check("rst_target", trap_target, 32'h0);
        check("rst_mepc", mepc_value, 32'h0);
        reset_n = 1;

        tick();
        // Legality and non-vectored mtvec
        peek("leg_7c0_val", 12'h7C0, 32'h0);
        check("leg_7c0", 32'(read_legal), 32'h0);
        peek("leg_b1f_val", 12'hB1F, 32'h0);
        check("leg_b1f", 32'(read_legal), 32'h1);
        wr(12'h305, 32'h101);
        address = 12'h305; #1;
        check("nv_mtvec_101", nv_read_value, 32'h100);
        check("v_mtvec_101", read_value, 32'h101);

        // Inhibit CY and IR; hpm3 keeps counting
        wr(12'h320, 32'h5);
        wr(12'hB00, 32'h100);
        wr(12'hB02, 32'h200);
        wr(12'hB03, 32'h0);
        for (int i = 0; i < 5; i++) begin
            retire = 1; hpm_event = (i < 3) ? 4'b0001 : 4'b0000;
            tick();
        end
        idle();
        peek("inh_mcycle", 12'hB00, 32'h100);
        peek("inh_minstret", 12'hB02, 32'h200);
        peek("inh_hpm3", 12'hB03, 32'h3);
        wr(12'h320, 32'h0);

        // Wrap at 2^40
        wr(12'hB80, 32'hFF);
        wr(12'hB00, 32'hFFFF_FFFF);
        tick();
        peek("wrap_lo", 12'hB00, 32'h0);
        peek("wrap_hi", 12'hB80, 32'h0);
        wr(12'hB80, 32'hFFFF_FFFF);
        peek("wrap_hi_trunc", 12'hB80, 32'hFF);

        // Vectored interrupt trap
        wr(12'h305, 32'h0000_1001);
        wr(12'h304, 32'h880);
        wr(12'h300, 32'h8);
        ext_irq = 1; tim_irq = 1;
        tick();
        #1;
        check("vec_irq_req", 32'(interrupt_request), 32'h1);
        check("vec_irq_code", 32'(interrupt_code), 32'd11);
        trap = 1; trap_interrupt = 1; trap_code = 5'd11; trap_pc = 32'h0000_2004;
        #1;
        check("vec_target", trap_target, 32'h0000_102C);
        tick();
        idle(); ext_irq = 0; tim_irq = 0;
        peek("vec_mcause", 12'h342, 32'h8000_000B);
        peek("vec_mstatus", 12'h300, 32'h1880);

        // Trap beats a same-cycle write; then mret
        wr(12'h300, 32'h8);
        address = 12'h340; write_value = 32'h1234; write_enable = 1;
        trap = 1; trap_code = 5'd2; trap_pc = 32'h8000_1237; trap_value = 32'hDEAD_BEEF;
        tick();
        idle();
        peek("prec_mscratch", 12'h340, 32'h0);
        peek("prec_mepc", 12'h341, 32'h8000_1234);
        peek("prec_mtval", 12'h343, 32'hDEAD_BEEF);
        return_from_trap = 1;
        tick();
        idle();
        peek("mret_mstatus", 12'h300, 32'h1888);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            address        = addr_pool[$urandom_range(0, 31)];
            write_value    = $urandom;
            if ($urandom_range(0, 3) == 0) write_value[31:8] = 24'hFFFFFF;
            write_enable   = ($urandom_range(0, 1) == 1);
            trap           = ($urandom_range(0, 9) == 0);
            return_from_trap = ($urandom_range(0, 9) == 0);
            trap_interrupt = $urandom_range(0, 1) == 1;
            trap_code      = 5'($urandom);
            trap_pc        = $urandom;
            trap_value     = $urandom;
            retire         = $urandom_range(0, 1) == 1;
            hpm_event      = 4'($urandom);
            ext_irq        = ($urandom_range(0, 3) == 0);
            tim_irq        = ($urandom_range(0, 3) == 0);
            sw_irq         = ($urandom_range(0, 3) == 0);
            tick();
        end

        // Asynchronous reset in the middle of counting
        idle(); ext_irq = 0; tim_irq = 0; sw_irq = 1;
        wr(12'h320, 32'h0);
        wr(12'h304, 32'h888);
        wr(12'h300, 32'h8);
        address = 12'hB00;
        repeat (10) tick();
        check("pre_rst_irq", 32'(interrupt_request), 32'h1);
        #2 reset_n = 0;
        peek("arst_mcycle", 12'hB00, 32'h0);
        check("arst_irq", 32'(interrupt_request), 32'h0);
        check("arst_code", 32'(interrupt_code), 32'h0);
        check("arst_target", trap_target, 32'h0);
        check("arst_mepc", mepc_value, 32'h0);
        model_reset();
        @(posedge clock);
        #1 reset_n = 1;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
